// File: rtl/pad_poll_sequencer.sv
// Polls a PS2-style game pad through the SPI master's byte interface: drives chip
// select, sends the fixed 5-byte command frame and publishes validated button/ID data.
module pad_poll_sequencer #(
    parameter int unsigned c_POLL_PERIOD_CLKS = 833333,
    parameter int unsigned c_CS_SETUP_CLKS    = 8,
    parameter int unsigned c_CS_HOLD_CLKS     = 8,
    parameter int unsigned c_GAP_CLKS         = 16,
    parameter int unsigned c_TIMEOUT_CLKS     = 1024
) (
    input  logic        i_CLK,
    input  logic        i_RESET,
    input  logic        i_ENABLE,
    input  logic        i_POLL_NOW,
    output logic [7:0]  o_TX_BYTE,
    output logic        o_TX_DV,
    input  logic        i_TX_READY,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_DATA,
    output logic        o_SPI_CS_n,
    output logic [15:0] o_BUTTONS,
    output logic [7:0]  o_ID,
    output logic        o_DATA_VALID,
    output logic        o_ERROR,
    output logic        o_BUSY
);

    localparam int unsigned c_MAX_A    = (c_CS_SETUP_CLKS > c_CS_HOLD_CLKS) ? c_CS_SETUP_CLKS : c_CS_HOLD_CLKS;
    localparam int unsigned c_MAX_B    = (c_GAP_CLKS > c_TIMEOUT_CLKS) ? c_GAP_CLKS : c_TIMEOUT_CLKS;
    localparam int unsigned c_WAIT_MAX = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int unsigned c_WAIT_W   = $clog2(c_WAIT_MAX + 1);
    localparam int unsigned c_POLL_W   = $clog2(c_POLL_PERIOD_CLKS + 1);

    // Setup and gap end one cycle early because o_TX_DV is registered out of SEND.
    localparam logic [c_WAIT_W-1:0] c_SETUP_LAST   = c_WAIT_W'(c_CS_SETUP_CLKS - 2);
    localparam logic [c_WAIT_W-1:0] c_GAP_LAST     = c_WAIT_W'(c_GAP_CLKS - 2);
    localparam logic [c_WAIT_W-1:0] c_HOLD_LAST    = c_WAIT_W'(c_CS_HOLD_CLKS - 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT_LAST = c_WAIT_W'(c_TIMEOUT_CLKS - 1);
    localparam logic [c_POLL_W-1:0] c_POLL_LAST    = c_POLL_W'(c_POLL_PERIOD_CLKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CS_SETUP, ST_SEND, ST_WAIT_RX, ST_GAP, ST_CS_HOLD, ST_CHECK, ST_ABORT
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [c_POLL_W-1:0] poll_cnt_r;
    logic [c_WAIT_W-1:0] wait_cnt_r;
    logic [2:0]          idx_r;
    logic [7:0]          rx_r [0:4];
    logic                start_s;
    logic                tx_fire_s;
    logic                rx_take_s;
    logic                check_ok_s;
    logic                check_bad_s;
    logic                abort_s;
    logic                frame_ok_s;

    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h01;
            3'd1:    b = 8'h42;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic cs_high(input state_t s);
        return (s == ST_IDLE) || (s == ST_CHECK) || (s == ST_ABORT);
    endfunction

    assign frame_ok_s = (rx_r[2] == 8'h5A);

    // Next-state decode and one-cycle control strobes.
    always_comb begin
        state_s     = state_r;
        start_s     = 1'b0;
        tx_fire_s   = 1'b0;
        rx_take_s   = 1'b0;
        check_ok_s  = 1'b0;
        check_bad_s = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_POLL_NOW || (i_ENABLE && (poll_cnt_r == c_POLL_LAST))) begin
                    start_s = 1'b1;
                    state_s = ST_CS_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CS_SETUP: begin
                if (wait_cnt_r == c_SETUP_LAST) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_CS_SETUP;
                end
            end
            ST_SEND: begin
                if (i_TX_READY) begin
                    tx_fire_s = 1'b1;
                    state_s   = ST_WAIT_RX;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_WAIT_RX: begin
                if (i_RX_DV) begin
                    rx_take_s = 1'b1;
                    if (idx_r == 3'd4) begin
                        state_s = ST_CS_HOLD;
                    end else begin
                        state_s = ST_GAP;
                    end
                end else if (wait_cnt_r == c_TIMEOUT_LAST) begin
                    abort_s = 1'b1;
                    state_s = ST_ABORT;
                end else begin
                    state_s = ST_WAIT_RX;
                end
            end
            ST_GAP: begin
                if (wait_cnt_r == c_GAP_LAST) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_CS_HOLD: begin
                if (wait_cnt_r == c_HOLD_LAST) begin
                    check_ok_s  = frame_ok_s;
                    check_bad_s = ~frame_ok_s;
                    state_s     = ST_CHECK;
                end else begin
                    state_s = ST_CS_HOLD;
                end
            end
            ST_CHECK: state_s = ST_IDLE;
            ST_ABORT: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register plus the per-state wait counter, cleared on every transition.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= '0;
        end else begin
            state_r <= state_s;
            if (state_s != state_r) begin
                wait_cnt_r <= '0;
            end else begin
                wait_cnt_r <= wait_cnt_r + c_WAIT_W'(1);
            end
        end
    end

    // Poll timer: runs only while idle and enabled.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            poll_cnt_r <= '0;
        end else if (start_s || !i_ENABLE) begin
            poll_cnt_r <= '0;
        end else if (state_r == ST_IDLE) begin
            poll_cnt_r <= poll_cnt_r + c_POLL_W'(1);
        end else begin
            poll_cnt_r <= poll_cnt_r;
        end
    end

    // Byte index and receive buffer; bytes are only captured while waiting for them.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            idx_r <= 3'd0;
            for (int i = 0; i < 5; i++) begin
                rx_r[i] <= 8'h00;
            end
        end else if (start_s) begin
            idx_r <= 3'd0;
        end else if (rx_take_s) begin
            rx_r[idx_r] <= i_RX_DATA;
            if (idx_r != 3'd4) begin
                idx_r <= idx_r + 3'd1;
            end
        end
    end

    // Registered outputs, all decoded from the state being entered.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            o_SPI_CS_n   <= 1'b1;
            o_TX_DV      <= 1'b0;
            o_TX_BYTE    <= 8'h00;
            o_BUTTONS    <= 16'hFFFF;
            o_ID         <= 8'h00;
            o_DATA_VALID <= 1'b0;
            o_ERROR      <= 1'b0;
            o_BUSY       <= 1'b0;
        end else begin
            o_SPI_CS_n   <= cs_high(state_s);
            o_BUSY       <= (state_s != ST_IDLE);
            o_TX_DV      <= tx_fire_s;
            o_DATA_VALID <= check_ok_s;
            o_ERROR      <= check_bad_s | abort_s;
            if (tx_fire_s) begin
                o_TX_BYTE <= cmd_byte(idx_r);
            end
            if (check_ok_s) begin
                o_ID      <= rx_r[1];
                o_BUTTONS <= {rx_r[4], rx_r[3]};
            end
        end
    end

endmodule

// File: tb/tb_pad_poll_sequencer.sv
// Directed bench for pad_poll_sequencer with a behavioural SPI master that answers
// each byte 16 cycles after o_TX_DV.
module tb_pad_poll_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        poll_now = 1'b0;
    logic        tx_ready = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  tx_byte;
    logic        tx_dv;
    logic        cs_n;
    logic [15:0] buttons;
    logic [7:0]  id;
    logic        data_valid;
    logic        error;
    logic        busy;

    pad_poll_sequencer #(.c_POLL_PERIOD_CLKS(100)) dut (
        .i_CLK(clk), .i_RESET(rst), .i_ENABLE(enable), .i_POLL_NOW(poll_now),
        .o_TX_BYTE(tx_byte), .o_TX_DV(tx_dv), .i_TX_READY(tx_ready),
        .i_RX_DV(rx_dv), .i_RX_DATA(rx_data), .o_SPI_CS_n(cs_n),
        .o_BUTTONS(buttons), .o_ID(id), .o_DATA_VALID(data_valid),
        .o_ERROR(error), .o_BUSY(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] cmd [0:4] = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
    logic [7:0] reply [0:4];
    int   respond_n = 5;
    bit   inject_spur = 1'b0;

    int   byte_k = 0, pend_cnt = 0, pend_k = 0, spur_cnt = 0;
    logic [7:0] pend_data;
    logic prev_cs = 1'b1;
    logic ready_at_edge = 1'b1;
    int   cs_falls[$];
    int   first_tx_cyc = 0, tx3_cyc = 0, err_cyc = 0;
    int   dv_count = 0, err_count = 0, txdv_viol = 0, tx_total = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        ready_at_edge <= tx_ready;
    end

    // Master model and output monitor, both acting on the falling edge.
    always @(negedge clk) begin
        rx_dv = 1'b0;
        if (rst) begin
            byte_k = 0; pend_cnt = 0; spur_cnt = 0; prev_cs = 1'b1;
        end else begin
            if (prev_cs && !cs_n) begin
                cs_falls.push_back(cyc);
                byte_k = 0;
            end
            prev_cs = cs_n;
            if (data_valid) dv_count++;
            if (error) begin err_count++; err_cyc = cyc; end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    rx_dv = 1'b1; rx_data = pend_data;
                    if (inject_spur && pend_k == 2) spur_cnt = 5;
                end
            end else if (spur_cnt > 0) begin
                spur_cnt--;
                if (spur_cnt == 0) begin rx_dv = 1'b1; rx_data = 8'h00; end
            end
            if (tx_dv) begin
                tx_total++;
                if (!ready_at_edge) txdv_viol++;
                if (byte_k < 5) chk("tx_byte", tx_byte, cmd[byte_k]);
                else chk("tx_extra_byte", byte_k, 4);
                if (byte_k == 0) first_tx_cyc = cyc;
                if (byte_k == 2) tx3_cyc = cyc;
                if (byte_k < respond_n && byte_k < 5) begin
                    pend_cnt = 16; pend_data = reply[byte_k]; pend_k = byte_k;
                end
                byte_k++;
            end
        end
    end

    task automatic start_poll();
        @(negedge clk) poll_now = 1'b1;
        @(negedge clk) poll_now = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 5000) begin @(negedge clk); n++; end
        chk(tag, busy, 1'b0);
        @(negedge clk);
    endtask

    task automatic wait_falls(input int target);
        int n = 0;
        while (cs_falls.size() < target && n < 2000) begin @(negedge clk); n++; end
        chk("cs_fall_wait", (cs_falls.size() >= target), 1'b1);
    endtask

    int dv0, err0, n0, en_cyc, t0;

    initial begin
        reply = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFF};
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_tx_dv", tx_dv, 1'b0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_buttons", buttons, 16'hFFFF);
        chk("rst_id", id, 8'h00);
        chk("rst_dv", data_valid, 1'b0);
        chk("rst_err", error, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Normal frame
        start_poll();
        wait_idle("frame1_done");
        chk("f1_tx_count", byte_k, 5);
        chk("f1_cs_setup", first_tx_cyc - cs_falls[cs_falls.size()-1], 8);
        chk("f1_dv", dv_count, 1);
        chk("f1_err", err_count, 0);
        chk("f1_id", id, 8'h41);
        chk("f1_buttons", buttons, 16'hFFFE);
        chk("f1_cs_n", cs_n, 1'b1);

        // Bad signature byte
        reply[2] = 8'h00;
        dv0 = dv_count; err0 = err_count;
        start_poll();
        wait_idle("frame2_done");
        chk("f2_dv", dv_count, dv0);
        chk("f2_err", err_count, err0 + 1);
        chk("f2_buttons", buttons, 16'hFFFE);
        chk("f2_id", id, 8'h41);

        // Master goes silent after two bytes
        reply[2] = 8'h5A;
        respond_n = 2;
        err0 = err_count;
        start_poll();
        wait_idle("frame3_done");
        chk("f3_err", err_count, err0 + 1);
        chk("f3_timeout_cycles", err_cyc - tx3_cyc, 1024);
        chk("f3_cs_n", cs_n, 1'b1);
        chk("f3_buttons", buttons, 16'hFFFE);
        respond_n = 5;
        reply = '{8'hFF, 8'h73, 8'h5A, 8'h7F, 8'hBF};
        dv0 = dv_count;
        start_poll();
        wait_idle("frame4_done");
        chk("f4_dv", dv_count, dv0 + 1);
        chk("f4_id", id, 8'h73);
        chk("f4_buttons", buttons, 16'hBF7F);

        // Periodic polling; a mid-frame i_POLL_NOW is dropped
        dv0 = dv_count;
        n0 = cs_falls.size();
        @(negedge clk) enable = 1'b1;
        en_cyc = cyc;
        wait_falls(n0 + 2);
        repeat (50) @(negedge clk);
        chk("per_busy_at_poll_now", busy, 1'b1);
        poll_now = 1'b1;
        @(negedge clk) poll_now = 1'b0;
        wait_falls(n0 + 3);
        enable = 1'b0;
        wait_idle("periodic_done");
        chk("per_first_start", cs_falls[n0] - en_cyc, 100);
        chk("per_period_1", cs_falls[n0+1] - cs_falls[n0], 266);
        chk("per_period_2", cs_falls[n0+2] - cs_falls[n0+1], 266);
        chk("per_frames", dv_count, dv0 + 3);
        chk("per_no_extra", cs_falls.size(), n0 + 3);

        // TX_READY stalled 50 cycles; spurious RX_DV in a gap
        reply = '{8'hFF, 8'h41, 8'h5A, 8'hEF, 8'hFD};
        inject_spur = 1'b1;
        tx_ready = 1'b0;
        dv0 = dv_count;
        @(negedge clk) poll_now = 1'b1;
        @(negedge clk) poll_now = 1'b0;
        repeat (49) @(negedge clk);
        tx_ready = 1'b1;
        wait_idle("stall_done");
        inject_spur = 1'b0;
        chk("stall_latency", first_tx_cyc - cs_falls[cs_falls.size()-1], 50);
        chk("stall_no_early_dv", txdv_viol, 0);
        chk("stall_tx_count", byte_k, 5);
        chk("stall_dv", dv_count, dv0 + 1);
        chk("stall_buttons", buttons, 16'hFDEF);

        // Reset during byte 3
        reply = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFF};
        t0 = tx_total;
        start_poll();
        begin
            int n = 0;
            while (tx_total < t0 + 3 && n < 2000) begin @(negedge clk); n++; end
        end
        chk("rst_mid_reached_byte3", tx_total, t0 + 3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_cs_n", cs_n, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_buttons", buttons, 16'hFFFF);
        chk("mid_rst_id", id, 8'h00);
        chk("mid_rst_tx_byte", tx_byte, 8'h00);
        chk("mid_rst_err", error, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        dv0 = dv_count;
        start_poll();
        wait_idle("post_rst_done");
        chk("post_rst_dv", dv_count, dv0 + 1);
        chk("post_rst_tx_count", byte_k, 5);
        chk("post_rst_id", id, 8'h41);
        chk("post_rst_buttons", buttons, 16'hFFFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pad_poll_sequencer.md
Name: pad_poll_sequencer

Overview:
- Sequences the SPI master's byte interface to poll a PS2-style game pad periodically.
- Owns chip-select and issues a fixed 5-byte command frame: 0x01, 0x42, 0x00, 0x00, 0x00.
- Captures the 5 response bytes, validates the frame and publishes button/ID registers to the game logic.
- Sits between the SPI master and the input-decoding logic; sole driver of the master's TX side.

Parameters:
- c_POLL_PERIOD_CLKS, 833333, i_CLK cycles between automatic poll starts (60 Hz at 50 MHz).
- c_CS_SETUP_CLKS, 8, cycles from CS_n falling to the first o_TX_DV.
- c_CS_HOLD_CLKS, 8, cycles from the last byte received to CS_n rising.
- c_GAP_CLKS, 16, idle cycles between one byte's i_RX_DV and the next o_TX_DV.
- c_TIMEOUT_CLKS, 1024, max cycles waiting for i_RX_DV after o_TX_DV.

Ports:
- i_CLK  in  1  system clock
- i_RESET  in  1  reset, asynchronous, active-high
- i_ENABLE  in  1  enables periodic polling
- i_POLL_NOW  in  1  single-cycle request for an immediate poll
- o_TX_BYTE  out  8  byte to the SPI master
- o_TX_DV  out  1  one-cycle strobe; o_TX_BYTE valid
- i_TX_READY  in  1  master ready for a byte
- i_RX_DV  in  1  master received-byte strobe
- i_RX_DATA  in  8  received byte, valid with i_RX_DV
- o_SPI_CS_n  out  1  pad chip select, active-low
- o_BUTTONS  out  16  {rx byte4, rx byte3}, active-low buttons as delivered
- o_ID  out  8  rx byte1 (pad mode ID)
- o_DATA_VALID  out  1  one-cycle pulse; o_BUTTONS/o_ID updated
- o_ERROR  out  1  one-cycle pulse; frame rejected or timed out
- o_BUSY  out  1  high from leaving IDLE until returning to IDLE

Behaviour:
- Reset values: o_SPI_CS_n=1, o_TX_DV=0, o_TX_BYTE=0x00, o_BUTTONS=0xFFFF, o_ID=0x00, o_DATA_VALID=0, o_ERROR=0, o_BUSY=0; FSM=IDLE, poll timer=0, byte index=0.
- Reset mid-frame aborts immediately; CS_n returns to 1 asynchronously.
- Poll timer:
  - Counts only in IDLE with i_ENABLE=1.
  - At c_POLL_PERIOD_CLKS-1, starts a poll.
  - Cleared on every poll start; held at 0 while i_ENABLE=0.
- i_POLL_NOW: starts a poll next cycle when in IDLE, regardless of i_ENABLE. Ignored (not queued) when o_BUSY=1. A simultaneous timer expiry starts one poll only.
- IDLE -> CS_SETUP: CS_n=0; wait c_CS_SETUP_CLKS.
- CS_SETUP -> SEND.
- SEND:
  - Wait for i_TX_READY=1, then assert o_TX_DV for exactly one cycle with o_TX_BYTE = command[index]. Go to WAIT_RX.
  - o_TX_DV never asserts while i_TX_READY=0.
- WAIT_RX:
  - On i_RX_DV, store i_RX_DATA in rx[index].
  - If index=4 -> CS_HOLD; else index+1 -> GAP.
  - If c_TIMEOUT_CLKS elapse without i_RX_DV -> ABORT.
- GAP: wait c_GAP_CLKS -> SEND.
- CS_HOLD: wait c_CS_HOLD_CLKS, then CS_n=1 -> CHECK.
- CHECK (one cycle):
  - If rx[2]==0x5A: o_ID<=rx[1], o_BUTTONS<={rx[4],rx[3]}, o_DATA_VALID pulse.
  - Otherwise: o_ERROR pulse, outputs unchanged.
  - Then -> IDLE.
- ABORT: CS_n=1 same cycle, o_ERROR pulse, outputs unchanged -> IDLE.
- i_RX_DV outside WAIT_RX is ignored; rx buffer is unchanged.
- i_ENABLE falling mid-frame: current frame completes normally.
- o_BUSY=0 only in IDLE; CS_n=1 in IDLE, CHECK and ABORT.
- Minimum frame length: setup + 5×(TX handshake + master byte time) + 4×c_GAP_CLKS + hold.

Test Plan:
- Reset then i_POLL_NOW with a master model (16-cycle bytes, replies 0xFF,0x41,0x5A,0xFE,0xFF) -> TX bytes 01,42,00,00,00 in order; CS_n low 8 cycles before the first o_TX_DV; o_DATA_VALID pulse; o_ID=0x41; o_BUTTONS=0xFFFE.
- Reply byte2=0x00 instead of 0x5A -> o_ERROR pulse, no o_DATA_VALID, o_BUTTONS stays at the previous value 0xFFFE.
- Master stops returning i_RX_DV after byte 2 -> o_ERROR exactly 1024 cycles after the third o_TX_DV; CS_n=1; next poll completes normally.
- i_ENABLE=1 with c_POLL_PERIOD_CLKS=100 -> poll starts repeat at 100 cycles plus frame length; i_POLL_NOW during a frame produces no extra frame.
- i_TX_READY held low 50 cycles in SEND -> o_TX_DV waits, then pulses once; spurious i_RX_DV in GAP leaves rx unchanged.
- Assert i_RESET mid byte 3 -> CS_n=1 and all outputs at reset values immediately; a post-reset i_POLL_NOW runs a full frame.
